// File: rtl/avg_rx_pkg.sv
// Shared types, default thresholds and the EMA step helper for the avg_color_rx receiver.
package avg_rx_pkg;

    typedef enum logic [1:0] {
        LVL_DARK   = 2'b00,
        LVL_NORMAL = 2'b01,
        LVL_BRIGHT = 2'b10
    } level_t;

    localparam int unsigned EMA_SHIFT_DEF    = 2;
    localparam logic [7:0]  DARK_LO_DEF      = 8'd40;
    localparam logic [7:0]  DARK_HI_DEF      = 8'd56;
    localparam logic [7:0]  BRIGHT_LO_DEF    = 8'd184;
    localparam logic [7:0]  BRIGHT_HI_DEF    = 8'd200;
    localparam logic [31:0] STALE_CYCLES_DEF = 32'd25000000;

    // The true result always lies in 0..255, so modulo-256 addition of the
    // floored signed step gives the exact value.
    function automatic logic [7:0] ema_step(input logic [7:0] smooth,
                                            input logic [7:0] color,
                                            input int unsigned shift);
        logic signed [8:0] diff_v;
        logic signed [8:0] step_v;
        diff_v = $signed({1'b0, color}) - $signed({1'b0, smooth});
        step_v = diff_v >>> shift;
        return smooth + 8'(step_v);
    endfunction

endpackage

// File: rtl/avg_color_rx_toggle_sync.sv
// Three-flop synchronizer for the upd toggle strobe, producing a registered
// single-cycle pulse per level change, ignored until the chain has refilled after reset.
module toggle_sync (
    input  logic VGA_CLK,
    input  logic RST_N,
    input  logic upd,
    output logic toggle
);

    logic       s1_r;
    logic       s2_r;
    logic       s3_r;
    logic [1:0] arm_r;
    logic       toggle_r;
    logic       armed_s;

    // A constant upd=1 across reset ripples through s1..s3 during the arm window.
    assign armed_s = (arm_r == 2'd3);

    // Synchronizer chain, arm counter and registered toggle pulse.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            s3_r     <= 1'b0;
            arm_r    <= 2'd0;
            toggle_r <= 1'b0;
        end else begin
            s1_r     <= upd;
            s2_r     <= s1_r;
            s3_r     <= s2_r;
            if (!armed_s) begin
                arm_r <= arm_r + 2'd1;
            end
            toggle_r <= armed_s & (s2_r ^ s3_r);
        end
    end

    assign toggle = toggle_r;

endmodule

// File: rtl/avg_color_rx.sv
// Receiver for the camera-average (color, upd) toggle interface: capture, EMA,
// brightness classification with hysteresis and stale detection. Optional PWM: AVG_COLOR_RX_PWM_EN.
module avg_color_rx
    import avg_rx_pkg::*;
#(
    parameter int unsigned EMA_SHIFT    = EMA_SHIFT_DEF,
    parameter logic [7:0]  DARK_LO      = DARK_LO_DEF,
    parameter logic [7:0]  DARK_HI      = DARK_HI_DEF,
    parameter logic [7:0]  BRIGHT_LO    = BRIGHT_LO_DEF,
    parameter logic [7:0]  BRIGHT_HI    = BRIGHT_HI_DEF,
    parameter logic [31:0] STALE_CYCLES = STALE_CYCLES_DEF
) (
    input  logic       VGA_CLK,
    input  logic       RST_N,
    input  logic [7:0] color,
    input  logic       upd,
    output logic [7:0] sample,
    output logic [7:0] smooth,
    output logic       sample_vld,
    output logic [1:0] level,
    output logic       stale,
    output logic       pwm
);

    logic        toggle_s;
    logic [7:0]  sample_r;
    logic [7:0]  smooth_r;
    logic        sample_vld_r;
    logic        primed_r;
    logic        stale_r;
    logic [31:0] stale_cnt_r;
    logic [31:0] stale_cnt_nxt_s;
    level_t      level_r;
    level_t      level_nxt_s;

    toggle_sync u_toggle_sync (
        .VGA_CLK (VGA_CLK),
        .RST_N   (RST_N),
        .upd     (upd),
        .toggle  (toggle_s)
    );

    // Saturating idle counter value for the coming edge.
    always_comb begin
        stale_cnt_nxt_s = stale_cnt_r;
        if (stale_cnt_r != 32'hFFFF_FFFF) begin
            stale_cnt_nxt_s = stale_cnt_r + 32'd1;
        end else begin
            stale_cnt_nxt_s = stale_cnt_r;
        end
    end

    // Capture, EMA update and stale tracking.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            sample_r     <= 8'd0;
            smooth_r     <= 8'd0;
            sample_vld_r <= 1'b0;
            primed_r     <= 1'b0;
            stale_r      <= 1'b1;
            stale_cnt_r  <= 32'd0;
        end else begin
            sample_vld_r <= toggle_s;
            if (toggle_s) begin
                sample_r    <= color;
                smooth_r    <= primed_r ? ema_step(smooth_r, color, EMA_SHIFT) : color;
                primed_r    <= 1'b1;
                stale_cnt_r <= 32'd0;
                stale_r     <= 1'b0;
            end else begin
                stale_cnt_r <= stale_cnt_nxt_s;
                stale_r     <= !primed_r || (stale_cnt_nxt_s >= STALE_CYCLES);
            end
        end
    end

    // Level state register.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            level_r <= LVL_NORMAL;
        end else begin
            level_r <= level_nxt_s;
        end
    end

    // Hysteresis transitions, judged on the smooth value registered with sample_vld.
    always_comb begin
        level_nxt_s = level_r;
        if (sample_vld_r) begin
            case (level_r)
                LVL_NORMAL: begin
                    if (smooth_r > BRIGHT_HI) begin
                        level_nxt_s = LVL_BRIGHT;
                    end else if (smooth_r < DARK_LO) begin
                        level_nxt_s = LVL_DARK;
                    end else begin
                        level_nxt_s = LVL_NORMAL;
                    end
                end
                LVL_DARK: begin
                    if (smooth_r > BRIGHT_HI) begin
                        level_nxt_s = LVL_BRIGHT;
                    end else if (smooth_r >= DARK_HI) begin
                        level_nxt_s = LVL_NORMAL;
                    end else begin
                        level_nxt_s = LVL_DARK;
                    end
                end
                LVL_BRIGHT: begin
                    if (smooth_r < DARK_LO) begin
                        level_nxt_s = LVL_DARK;
                    end else if (smooth_r <= BRIGHT_LO) begin
                        level_nxt_s = LVL_NORMAL;
                    end else begin
                        level_nxt_s = LVL_BRIGHT;
                    end
                end
                default: begin
                    level_nxt_s = LVL_NORMAL;
                end
            endcase
        end else begin
            level_nxt_s = level_r;
        end
    end

`ifdef AVG_COLOR_RX_PWM_EN
    logic [7:0] pc_r;
    logic       pwm_r;

    // Free-running PWM counter compared against the smoothed level.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            pc_r  <= 8'd0;
            pwm_r <= 1'b0;
        end else begin
            pc_r  <= pc_r + 8'd1;
            pwm_r <= (pc_r < smooth_r) && !stale_r;
        end
    end

    assign pwm = pwm_r;
`else
    assign pwm = 1'b0;
`endif

    assign sample     = sample_r;
    assign smooth     = smooth_r;
    assign sample_vld = sample_vld_r;
    assign level      = level_r;
    assign stale      = stale_r;

endmodule
